coin_change_unit: RTL and testbench

COIN_CHANGE_UNIT -- requirements
Module: coin_change_unit

---
 rtl/coin_change_unit.sv | 216 +++++++++++++++++++++
 tb/tb_coin_change_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_change_unit.sv
// ============================================================================
// coin_change_unit
// ----------------------------------------------------------------------------
// Purpose:
//   Credit and change controller for a drink vending machine. It accepts coins
//   up to MAX_AMOUNT units of credit, commits a purchase when there is enough
//   credit and the brewer is free, and then pays back any remainder (or the
//   whole credit on cancel) one coin at a time. Each change coin is the
//   largest one that still fits.
//
// Ports:
//   clk          in   1  system clock, rising edge
//   rst          in   1  asynchronous reset, active low
//   coin_valid   in   1  one-cycle pulse: a coin was inserted
//   coin_sel     in   2  coin value: 00=1, 01=2, 10=5, 11=10 units
//   sel_valid    in   1  one-cycle pulse: drink purchase request
//   cost         in   3  drink cost in units, sampled with sel_valid
//   cancel       in   1  one-cycle pulse: refund the whole credit
//   brew_busy    in   1  serving sequence is running
//   change_ack   in   1  dispenser accepted the presented change coin
//   credit       out  5  current credit
//   coin_reject  out  1  one-cycle pulse for each coin not accepted
//   insufficient out  1  one-cycle pulse: selection refused for lack of credit
//   brew_start   out  1  high for the single VEND cycle
//   change_valid out  1  a change coin is being presented
//   change_coin  out  2  presented change coin, same encoding as coin_sel
//   dbg_state    out  2  FSM state (0=IDLE, 1=COLLECT, 2=VEND, 3=CHANGE)
//
// Change handshake: a coin transfers on a rising edge where change_valid and
// change_ack are both high. change_valid stays high and change_coin stays
// stable until that edge; change_ack on its own has no effect.
// ============================================================================
module coin_change_unit #(
    parameter int MAX_AMOUNT = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [1:0] coin_sel,
    input  logic       sel_valid,
    input  logic [2:0] cost,
    input  logic       cancel,
    input  logic       brew_busy,
    input  logic       change_ack,
    output logic [4:0] credit,
    output logic       coin_reject,
    output logic       insufficient,
    output logic       brew_start,
    output logic       change_valid,
    output logic [1:0] change_coin,
    output logic [1:0] dbg_state
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] VEND    = 2'd2;
    localparam logic [1:0] CHANGE  = 2'd3;

    localparam logic [5:0] MAX_CREDIT = 6'(MAX_AMOUNT);

    // Credit is held one bit wider than the output so that sums and
    // differences never wrap before they are range-checked.
    logic [1:0] r_state;
    logic [5:0] r_credit;
    logic [2:0] r_cost;
    logic       r_coin_reject;
    logic       r_insufficient;

    logic [1:0] w_state_nxt;
    logic [5:0] w_credit_nxt;
    logic [2:0] w_cost_nxt;

    logic       w_active;
    logic [5:0] w_coin_val;
    logic [5:0] w_coin_sum;
    logic       w_coin_fits;
    logic       w_coin_take;
    logic       w_coin_rej;
    logic       w_do_cancel;
    logic       w_sel_req;
    logic       w_sel_short;
    logic       w_sel_go;
    logic [5:0] w_cost_ext;
    logic [5:0] w_vend_rem;
    logic [1:0] w_chg_code;
    logic [5:0] w_chg_val;
    logic [5:0] w_chg_rem;

    // ------------------------------------------------------------------
    // Input decode
    // ------------------------------------------------------------------
    always_comb begin
        w_coin_val = 6'd1;
        case (coin_sel)
            2'b00:   w_coin_val = 6'd1;
            2'b01:   w_coin_val = 6'd2;
            2'b10:   w_coin_val = 6'd5;
            default: w_coin_val = 6'd10;
        endcase
    end

    assign w_active    = (r_state == IDLE) || (r_state == COLLECT);
    assign w_coin_sum  = r_credit + w_coin_val;
    assign w_coin_fits = (w_coin_sum <= MAX_CREDIT);

    // cancel outranks sel_valid, which outranks coin_valid. A raised cancel
    // blocks a selection even in IDLE, where the cancel itself does nothing.
    assign w_do_cancel = w_active && cancel && (r_state == COLLECT);
    assign w_sel_req   = w_active && !cancel && sel_valid && (cost != 3'd0);
    assign w_cost_ext  = {3'b000, cost};
    assign w_sel_short = w_sel_req && (r_credit < w_cost_ext);
    assign w_sel_go    = w_sel_req && !w_sel_short && !brew_busy;

    // A coin is taken only when nothing of higher priority is asserted in
    // the same cycle and it keeps the credit within range.
    assign w_coin_take = w_active && coin_valid && !cancel && !sel_valid
                         && w_coin_fits;
    assign w_coin_rej  = coin_valid && !w_coin_take;

    // Remainder after the purchase; clamped so a corrupted cost can never
    // wrap the credit around.
    assign w_vend_rem = (r_credit >= {3'b000, r_cost})
                        ? (r_credit - {3'b000, r_cost}) : 6'd0;

    // ------------------------------------------------------------------
    // Greedy change coin: largest of 10, 5, 2, 1 not exceeding the credit
    // ------------------------------------------------------------------
    always_comb begin
        w_chg_code = 2'b00;
        w_chg_val  = 6'd1;
        if (r_credit >= 6'd10) begin
            w_chg_code = 2'b11;
            w_chg_val  = 6'd10;
        end else if (r_credit >= 6'd5) begin
            w_chg_code = 2'b10;
            w_chg_val  = 6'd5;
        end else if (r_credit >= 6'd2) begin
            w_chg_code = 2'b01;
            w_chg_val  = 6'd2;
        end
    end

    assign w_chg_rem = (r_credit >= w_chg_val) ? (r_credit - w_chg_val) : 6'd0;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_cost_nxt   = r_cost;
        case (r_state)
            IDLE, COLLECT: begin
                if (w_do_cancel) begin
                    w_state_nxt = CHANGE;
                end else if (w_sel_go) begin
                    w_state_nxt = VEND;
                    w_cost_nxt  = cost;
                end else if (w_coin_take) begin
                    w_credit_nxt = w_coin_sum;
                    w_state_nxt  = COLLECT;
                end
            end
            VEND: begin
                w_credit_nxt = w_vend_rem;
                w_state_nxt  = (w_vend_rem == 6'd0) ? IDLE : CHANGE;
            end
            CHANGE: begin
                if (r_credit == 6'd0) begin
                    w_state_nxt = IDLE;
                end else if (change_ack) begin
                    w_credit_nxt = w_chg_rem;
                    if (w_chg_rem == 6'd0) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_credit_nxt = 6'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_credit       <= 6'd0;
            r_cost         <= 3'd0;
            r_coin_reject  <= 1'b0;
            r_insufficient <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_credit       <= w_credit_nxt;
            r_cost         <= w_cost_nxt;
            r_coin_reject  <= w_coin_rej;
            r_insufficient <= w_sel_short;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Change and brew outputs decode the state directly so that
    // reset removes them without waiting for a clock edge.
    // ------------------------------------------------------------------
    assign credit       = r_credit[4:0];
    assign coin_reject  = r_coin_reject;
    assign insufficient = r_insufficient;
    assign brew_start   = (r_state == VEND);
    assign change_valid = (r_state == CHANGE) && (r_credit != 6'd0);
    assign change_coin  = change_valid ? w_chg_code : 2'b00;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_coin_change_unit.sv
module tb_coin_change_unit;

  localparam int ST_IDLE    = 0;
  localparam int ST_COLLECT = 1;
  localparam int ST_VEND    = 2;
  localparam int ST_CHANGE  = 3;

  logic       clk;
  logic       rst;
  logic       coin_valid;
  logic [1:0] coin_sel;
  logic       sel_valid;
  logic [2:0] cost;
  logic       cancel;
  logic       brew_busy;
  logic       change_ack;
  logic [4:0] credit;
  logic       coin_reject;
  logic       insufficient;
  logic       brew_start;
  logic       change_valid;
  logic [1:0] change_coin;
  logic [1:0] dbg_state;

  int n_cmp;
  int n_bad;

  // expected change coin codes, in order of presentation
  logic [1:0] exp_q[$];

  coin_change_unit #(.MAX_AMOUNT(20)) dut (
    .clk          (clk),
    .rst          (rst),
    .coin_valid   (coin_valid),
    .coin_sel     (coin_sel),
    .sel_valid    (sel_valid),
    .cost         (cost),
    .cancel       (cancel),
    .brew_busy    (brew_busy),
    .change_ack   (change_ack),
    .credit       (credit),
    .coin_reject  (coin_reject),
    .insufficient (insufficient),
    .brew_start   (brew_start),
    .change_valid (change_valid),
    .change_coin  (change_coin),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // inputs change 1 time unit after a rising edge; outputs are read there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(input logic [1:0] sel);
    coin_valid = 1'b1;
    coin_sel   = sel;
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic select(input logic [2:0] c);
    sel_valid = 1'b1;
    cost      = c;
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
  endtask

  // Consume exp_q: each coin must be held for 'delay' unacked cycles, then acked.
  task automatic drain(input string tag, input int delay);
    logic [1:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int d = 0; d < delay; d++) begin
        check_eq({tag, "_hold_valid"}, 32'(change_valid), 1);
        check_eq({tag, "_hold_coin"}, 32'(change_coin), 32'(e));
        tick();
      end
      check_eq({tag, "_valid"}, 32'(change_valid), 1);
      check_eq({tag, "_coin"}, 32'(change_coin), 32'(e));
      change_ack = 1'b1;
      tick();
      change_ack = 1'b0;
    end
    check_eq({tag, "_end_state"}, 32'(dbg_state), ST_IDLE);
    check_eq({tag, "_end_credit"}, 32'(credit), 0);
    check_eq({tag, "_end_valid"}, 32'(change_valid), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    rst        = 1'b0;
    coin_valid = 1'b0;
    coin_sel   = 2'b00;
    sel_valid  = 1'b0;
    cost       = 3'd0;
    cancel     = 1'b0;
    brew_busy  = 1'b0;
    change_ack = 1'b0;
    tick();
    tick();
    check_eq("rst_credit", 32'(credit), 0);
    check_eq("rst_state", 32'(dbg_state), ST_IDLE);
    check_eq("rst_valid", 32'(change_valid), 0);
    check_eq("rst_brew", 32'(brew_start), 0);
    rst = 1'b1;
    tick();

    // coins 5,2,1 then purchase cost 6, remainder 2 paid back as one 2-coin
    put_coin(2'b10);
    check_eq("c5_credit", 32'(credit), 5);
    check_eq("c5_state", 32'(dbg_state), ST_COLLECT);
    put_coin(2'b01);
    put_coin(2'b00);
    check_eq("c8_credit", 32'(credit), 8);
    select(3'd6);
    check_eq("vend_state", 32'(dbg_state), ST_VEND);
    check_eq("vend_brew", 32'(brew_start), 1);
    check_eq("vend_credit", 32'(credit), 8);
    put_coin(2'b00);  // arrives during VEND
    check_eq("postvend_credit", 32'(credit), 2);
    check_eq("postvend_brew", 32'(brew_start), 0);
    check_eq("vend_coin_rej", 32'(coin_reject), 1);
    check_eq("postvend_state", 32'(dbg_state), ST_CHANGE);
    exp_q.push_back(2'b01);
    drain("buy6", 0);

    // stray ack in IDLE does nothing
    change_ack = 1'b1;
    tick();
    change_ack = 1'b0;
    check_eq("stray_ack_credit", 32'(credit), 0);
    check_eq("stray_ack_state", 32'(dbg_state), ST_IDLE);

    // overflow: 18 + 5 rejected, 18 + 2 = 20 accepted; refund 10,10
    put_coin(2'b11);
    put_coin(2'b10);
    put_coin(2'b01);
    put_coin(2'b00);
    check_eq("c18_credit", 32'(credit), 18);
    put_coin(2'b10);
    check_eq("ovf_rej", 32'(coin_reject), 1);
    check_eq("ovf_credit", 32'(credit), 18);
    put_coin(2'b01);
    check_eq("max_rej", 32'(coin_reject), 0);
    check_eq("max_credit", 32'(credit), 20);
    do_cancel();
    check_eq("cancel20_state", 32'(dbg_state), ST_CHANGE);
    check_eq("cancel20_credit", 32'(credit), 20);
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b11);
    drain("ref20", 1);

    // insufficient credit, zero cost, busy brewer
    put_coin(2'b01);
    put_coin(2'b00);
    select(3'd5);
    check_eq("insuf_pulse", 32'(insufficient), 1);
    check_eq("insuf_credit", 32'(credit), 3);
    check_eq("insuf_state", 32'(dbg_state), ST_COLLECT);
    tick();
    check_eq("insuf_once", 32'(insufficient), 0);
    select(3'd0);
    check_eq("cost0_insuf", 32'(insufficient), 0);
    check_eq("cost0_state", 32'(dbg_state), ST_COLLECT);
    put_coin(2'b01);
    put_coin(2'b01);
    check_eq("c7_credit", 32'(credit), 7);
    brew_busy = 1'b1;
    select(3'd5);
    check_eq("busy_insuf", 32'(insufficient), 0);
    check_eq("busy_state", 32'(dbg_state), ST_COLLECT);
    tick();
    check_eq("busy_brew", 32'(brew_start), 0);
    check_eq("busy_credit", 32'(credit), 7);
    brew_busy = 1'b0;
    do_cancel();
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    drain("ref7", 0);

    // cancel from 18 with ack held off 3 cycles per coin
    put_coin(2'b11);
    put_coin(2'b10);
    put_coin(2'b01);
    put_coin(2'b00);
    do_cancel();
    check_eq("cancel18_credit", 32'(credit), 18);
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b00);
    drain("ref18", 3);

    // cancel, select and coin together at credit 9
    put_coin(2'b10);
    put_coin(2'b01);
    put_coin(2'b01);
    check_eq("c9_credit", 32'(credit), 9);
    cancel     = 1'b1;
    sel_valid  = 1'b1;
    cost       = 3'd3;
    coin_valid = 1'b1;
    coin_sel   = 2'b00;
    tick();
    cancel     = 1'b0;
    sel_valid  = 1'b0;
    coin_valid = 1'b0;
    check_eq("prio_state", 32'(dbg_state), ST_CHANGE);
    check_eq("prio_rej", 32'(coin_reject), 1);
    check_eq("prio_credit", 32'(credit), 9);
    check_eq("prio_brew", 32'(brew_start), 0);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b01);
    drain("ref9", 0);

    // reset in the middle of CHANGE
    put_coin(2'b11);
    put_coin(2'b00);
    do_cancel();
    check_eq("pre_rst_valid", 32'(change_valid), 1);
    check_eq("pre_rst_coin", 32'(change_coin), 3);
    put_coin(2'b00);  // arrives during CHANGE
    check_eq("chg_coin_rej", 32'(coin_reject), 1);
    check_eq("chg_coin_credit", 32'(credit), 11);
    coin_valid = 1'b1;
    coin_sel   = 2'b11;
    tick();           // second rejected coin: coin_reject is high going into reset
    coin_valid = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check_eq("arst_valid", 32'(change_valid), 0);
    check_eq("arst_coin", 32'(change_coin), 0);
    check_eq("arst_credit", 32'(credit), 0);
    check_eq("arst_rej", 32'(coin_reject), 0);
    check_eq("arst_state", 32'(dbg_state), ST_IDLE);
    #1;
    rst = 1'b1;
    put_coin(2'b01);
    check_eq("post_rst_credit", 32'(credit), 2);
    check_eq("post_rst_state", 32'(dbg_state), ST_COLLECT);
    do_cancel();
    exp_q.push_back(2'b01);
    drain("ref2", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
